instruction_dispatcher: RTL and testbench

- Reader end of the instruction stack: drives the stack's pop strobe and captures the popped 24-bit instruction word.
- Splits the word into opcode/operand fields and presents it to the ALU sequencer over a valid/ready handshake.
- Tracks stack occupancy by monitoring the producer's push strobe, so it never pops an empty stack.

---
 rtl/instruction_dispatcher.sv | 123 ++++++++++++
 tb/tb_instruction_dispatcher.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_dispatcher.sv
// Reader end of the instruction stack: pops words, splits them into op/a/b fields and hands them to the ALU sequencer.
// Define DISPATCH_ERR_EN to add a sticky err output flagging stack overflow and push/pop collisions.
module instruction_dispatcher #(
  parameter int WIDTH   = 24,
  parameter int DEPTH   = 255,
  parameter int POP_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_mon,
  output logic             stk_pop,
  input  logic [WIDTH-1:0] stk_data,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [WIDTH-17:0] ins_op,
  output logic [7:0]       ins_a,
  output logic [7:0]       ins_b,
  output logic [7:0]       depth,
  output logic             empty
`ifdef DISPATCH_ERR_EN
 ,output logic             err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_SETTLE
  } state_t;

  localparam int CNT_W = (POP_LAT > 2) ? $clog2(POP_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((POP_LAT > 1) ? POP_LAT - 2 : 0);
  localparam logic [7:0] DEPTH_MAX = 8'(DEPTH);

  state_t r_state;
  state_t w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [7:0] r_depth;
  logic r_guard;
  logic r_valid;
  logic [WIDTH-17:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic w_can_pop;
  logic w_pop;

  // The stack ignores requests in its first push cycle, hence the one-cycle guard after every push.
  assign w_can_pop = (r_depth != 8'd0) && !push_mon && !r_guard && (!r_valid || ins_ready);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_pop) begin
          w_pop  = 1'b1;
          w_next = (POP_LAT > 1) ? S_WAIT : S_CAPTURE;
        end
      end
      S_WAIT:    if (r_wait_cnt == WAIT_LAST) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SETTLE;
      S_SETTLE:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_guard    <= 1'b0;
      r_depth    <= 8'd0;
    end else begin
      r_state <= w_next;
      r_guard <= push_mon;
      if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                   r_wait_cnt <= '0;
      if (push_mon) begin
        if (r_depth != DEPTH_MAX) r_depth <= r_depth + 8'd1;
      end else if (w_pop) begin
        r_depth <= r_depth - 8'd1;
      end
    end
  end

  // Single output slot: a new word only arrives after the previous one was accepted at pop time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
    end else if (r_state == S_CAPTURE) begin
      r_valid <= 1'b1;
      r_op    <= stk_data[WIDTH-1:16];
      r_a     <= stk_data[15:8];
      r_b     <= stk_data[7:0];
    end else if (r_valid && ins_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef DISPATCH_ERR_EN
  logic r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else if (push_mon && ((r_depth == DEPTH_MAX) || w_pop)) r_err <= 1'b1;
  end
  assign err = r_err;
`endif

  assign stk_pop   = w_pop;
  assign ins_valid = r_valid;
  assign ins_op    = r_op;
  assign ins_a     = r_a;
  assign ins_b     = r_b;
  assign depth     = r_depth;
  assign empty     = (r_depth == 8'd0);

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher; the bench plays the stack, supplying stk_data POP_LAT cycles after each pop.
// Covers err checks when compiled with DISPATCH_ERR_EN.
module tb_instruction_dispatcher;

  localparam logic [23:0] GARB = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_mon;
  logic        stk_pop;
  logic [23:0] stk_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [7:0]  ins_op;
  logic [7:0]  ins_a;
  logic [7:0]  ins_b;
  logic [7:0]  depth;
  logic        empty;
`ifdef DISPATCH_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  instruction_dispatcher #(.WIDTH(24), .DEPTH(255), .POP_LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .push_mon  (push_mon),
    .stk_pop   (stk_pop),
    .stk_data  (stk_data),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_op    (ins_op),
    .ins_a     (ins_a),
    .ins_b     (ins_b),
    .depth     (depth),
    .empty     (empty)
`ifdef DISPATCH_ERR_EN
   ,.err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    push_mon  = 1'b0;
    ins_ready = 1'b0;
    stk_data  = GARB;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Starts in the cycle after a pop; presents the word in the sample cycle and checks the fields one cycle later.
  task automatic serve(input logic [23:0] word, input string tag);
    mid();
    checks++; if (stk_pop !== 1'b0) begin errors++; $display("FAIL %s wait_pop got %b exp 0", tag, stk_pop); end
    step();
    stk_data = word;
    mid();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid got %b exp 0", tag, ins_valid); end
    step();
    stk_data = GARB;
    mid();
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL %s valid got %b exp 1", tag, ins_valid); end
    checks++; if ({ins_op, ins_a, ins_b} !== word) begin errors++; $display("FAIL %s fields got %h_%h_%h exp %h", tag, ins_op, ins_a, ins_b, word); end
    step();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    push_mon  = 1'b0;
    ins_ready = 1'b0;
    stk_data  = GARB;
    mid();
    checks++; if ({stk_pop, ins_valid, ins_op, ins_a, ins_b} !== 26'd0) begin errors++; $display("FAIL reset_outs got %b%b_%h%h%h exp 0", stk_pop, ins_valid, ins_op, ins_a, ins_b); end
    checks++; if ({depth, empty} !== 9'b0_0000_0001) begin errors++; $display("FAIL reset_depth got %0d/%b exp 0/1", depth, empty); end
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      push_mon = (c == 2 || c == 4);
      mid();
      checks++; if (stk_pop !== 1'b0) begin errors++; $display("FAIL pp_early_pop c%0d got %b exp 0", c, stk_pop); end
      step();
    end
    push_mon = 1'b0;
    mid();
    checks++; if (stk_pop !== 1'b1 || depth !== 8'd2) begin errors++; $display("FAIL pp_first_pop got %b/%0d exp 1/2", stk_pop, depth); end
    step();
    serve(24'h0B0304, "pp_w1");
    mid();
    checks++; if (stk_pop !== 1'b0 || ins_valid !== 1'b1) begin errors++; $display("FAIL pp_hold got %b/%b exp 0/1", stk_pop, ins_valid); end
    step();
    ins_ready = 1'b1;
    mid();
    checks++; if (stk_pop !== 1'b1) begin errors++; $display("FAIL pp_accept_pop got %b exp 1", stk_pop); end
    step();
    ins_ready = 1'b0;
    serve(24'h0A0102, "pp_w2");
    mid();
    checks++; if (depth !== 8'd0 || empty !== 1'b1) begin errors++; $display("FAIL pp_drained got %0d/%b exp 0/1", depth, empty); end
    ins_ready = 1'b1;
    step();
    mid();
    checks++; if (ins_valid !== 1'b0 || stk_pop !== 1'b0) begin errors++; $display("FAIL pp_final got %b/%b exp 0/0", ins_valid, stk_pop); end
    step();
  endtask

  task automatic test_empty_idle();
    ins_ready = 1'b1;
    push_mon  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      mid();
      checks++; if (stk_pop !== 1'b0 || ins_valid !== 1'b0) begin errors++; $display("FAIL empty_idle c%0d got %b/%b exp 0/0", c, stk_pop, ins_valid); end
      step();
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      push_mon = (c < 4);
      mid();
      checks++; if (stk_pop !== 1'b0) begin errors++; $display("FAIL hold_early_pop c%0d got %b exp 0", c, stk_pop); end
      step();
    end
    push_mon = 1'b0;
    mid();
    checks++; if (stk_pop !== 1'b1 || depth !== 8'd4) begin errors++; $display("FAIL hold_pop got %b/%0d exp 1/4", stk_pop, depth); end
    step();
    serve(24'h123456, "hold_w");
    for (int c = 0; c < 10; c++) begin
      mid();
      checks++;
      if (stk_pop !== 1'b0 || ins_valid !== 1'b1 || {ins_op, ins_a, ins_b} !== 24'h123456 || depth !== 8'd3) begin
        errors++; $display("FAIL hold_stable c%0d got %b/%b/%h%h%h/%0d exp 0/1/123456/3", c, stk_pop, ins_valid, ins_op, ins_a, ins_b, depth);
      end
      step();
    end
    ins_ready = 1'b1;
    mid();
    checks++; if (stk_pop !== 1'b1 || ins_valid !== 1'b1) begin errors++; $display("FAIL hold_accept_pop got %b/%b exp 1/1", stk_pop, ins_valid); end
    step();
  endtask

  // Continues from test_hold: the dispatcher is in the wait cycle of a pop.
  task automatic test_reset_mid_wait();
    ins_ready = 1'b0;
    mid();
    checks++; if (stk_pop !== 1'b0 || depth !== 8'd2) begin errors++; $display("FAIL rw_pre got %b/%0d exp 0/2", stk_pop, depth); end
    reset = 1'b1;
    #1;
    checks++; if ({ins_op, ins_a, ins_b} !== 24'd0 || depth !== 8'd0 || empty !== 1'b1 || stk_pop !== 1'b0) begin
      errors++; $display("FAIL rw_async got %h%h%h/%0d/%b/%b exp 0/0/1/0", ins_op, ins_a, ins_b, depth, empty, stk_pop);
    end
    stk_data = 24'h777777;
    step();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mid();
      checks++; if (ins_valid !== 1'b0 || stk_pop !== 1'b0) begin errors++; $display("FAIL rw_no_capture c%0d got %b/%b exp 0/0", c, ins_valid, stk_pop); end
      step();
    end
    stk_data = GARB;
  endtask

  task automatic test_push_collision();
    do_reset();
    ins_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push_mon = (c == 0 || c == 2);
      mid();
      checks++; if (stk_pop !== 1'b0) begin errors++; $display("FAIL col_pop c%0d got %b exp 0", c, stk_pop); end
      if (c == 3) begin
        checks++; if (depth !== 8'd2) begin errors++; $display("FAIL col_depth got %0d exp 2", depth); end
      end
      step();
    end
    push_mon = 1'b0;
    mid();
    checks++; if (stk_pop !== 1'b1) begin errors++; $display("FAIL col_pop_push2 got %b exp 1", stk_pop); end
    step();
    serve(24'h0C0506, "col_w1");
    mid();
    checks++; if (stk_pop !== 1'b1 || ins_valid !== 1'b0) begin errors++; $display("FAIL col_spacing got %b/%b exp 1/0", stk_pop, ins_valid); end
    step();
    serve(24'h0D0708, "col_w2");
    mid();
    checks++; if (depth !== 8'd0 || empty !== 1'b1 || ins_valid !== 1'b0 || stk_pop !== 1'b0) begin
      errors++; $display("FAIL col_drained got %0d/%b/%b/%b exp 0/1/0/0", depth, empty, ins_valid, stk_pop);
    end
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push_mon = 1'b1;
      mid();
      if (i == 255) begin
        checks++; if (depth !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", depth); end
`ifdef DISPATCH_ERR_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", err); end
`endif
      end
      step();
    end
    push_mon = 1'b0;
    mid();
    checks++; if (depth !== 8'd255 || stk_pop !== 1'b0) begin errors++; $display("FAIL sat_hold got %0d/%b exp 255/0", depth, stk_pop); end
`ifdef DISPATCH_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
`endif
    step();
    mid();
    checks++; if (stk_pop !== 1'b1) begin errors++; $display("FAIL sat_pop got %b exp 1", stk_pop); end
    step();
    mid();
`ifdef DISPATCH_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
`endif
    do_reset();
    mid();
    checks++; if (depth !== 8'd0) begin errors++; $display("FAIL sat_reset got %0d exp 0", depth); end
`ifdef DISPATCH_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset got %b exp 0", err); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_empty_idle();
    test_hold();
    test_reset_mid_wait();
    test_push_collision();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
